// File: rtl/osc_pkg.sv
// ---------------------------------------------------------------------------
// osc_pkg
// Shared definitions for the oscilloscope acquisition stage: default widths,
// trigger slope encoding and the acquisition state enum.
// ---------------------------------------------------------------------------
package osc_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_ADDR_W    = 9;
    localparam int DEF_PRE_DEPTH = 128;

    localparam logic SLOPE_RISE = 1'b0;
    localparam logic SLOPE_FALL = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        ARMED = 3'd2,
        POST  = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Acquisition is in progress in every state that writes samples.
    function automatic logic state_is_busy(input state_t s);
        return (s == FILL) || (s == ARMED) || (s == POST);
    endfunction

endpackage

// File: rtl/trigger_capture_if.sv
// ---------------------------------------------------------------------------
// trigger_capture_if
// Bundles the acquisition control inputs, status flags and record read port
// of trigger_capture.
//   master : drives tick_in, adc_data, arm, force_trig, trig_level,
//            trig_slope, rd_addr; observes busy, triggered, done, rd_data
//   slave  : the capture block itself (opposite directions)
// ---------------------------------------------------------------------------
interface trigger_capture_if
    import osc_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);

    logic              tick_in;
    logic [DATA_W-1:0] adc_data;
    logic              arm;
    logic              force_trig;
    logic [DATA_W-1:0] trig_level;
    logic              trig_slope;
    logic              busy;
    logic              triggered;
    logic              done;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output tick_in, adc_data, arm, force_trig, trig_level, trig_slope, rd_addr,
        input  busy, triggered, done, rd_data
    );

    modport slave (
        input  tick_in, adc_data, arm, force_trig, trig_level, trig_slope, rd_addr,
        output busy, triggered, done, rd_data
    );

endinterface

// File: rtl/capture_ram.sv
// ---------------------------------------------------------------------------
// capture_ram
// Simple dual-port sample store: one write port, one registered read port.
// Storage has no reset so it maps onto block RAM; only the read output
// register is cleared by rst.
//   clk, rst          : system clock, synchronous active-high reset
//   wr_en/addr/data   : write port
//   rd_addr / rd_data : read port, 1-cycle latency
// ---------------------------------------------------------------------------
module capture_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [DATA_W-1:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Kept in its own process so the storage array stays free of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_reg <= '0;
        end else begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/trigger_capture.sv
// ---------------------------------------------------------------------------
// trigger_capture
// Oscilloscope acquisition stage. Samples adc_data on each rising edge of the
// divided sample clock tick_in, keeps PRE_DEPTH samples of pre-trigger
// history in a circular buffer, detects a level/slope (or forced) trigger,
// captures the remaining DEPTH-PRE_DEPTH-1 post-trigger samples and freezes.
// The frozen record is read trigger-aligned: rd_addr 0 is the oldest sample,
// rd_addr PRE_DEPTH is the trigger sample.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : trigger_capture_if.slave (control, status, read port)
// ---------------------------------------------------------------------------
module trigger_capture
    import osc_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int PRE_DEPTH = DEF_PRE_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    trigger_capture_if.slave   bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] PRE_A      = ADDR_W'(PRE_DEPTH);
    localparam logic [ADDR_W-1:0] POST_INIT  = ADDR_W'(DEPTH - PRE_DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE_A      = ADDR_W'(1);
    localparam logic              POST_EMPTY = ((DEPTH - PRE_DEPTH - 1) == 0);

    // ---------------- state ----------------
    state_t            state_reg,      state_next;
    logic              tick_q_reg;
    logic [DATA_W-1:0] prev_reg,       prev_next;
    logic              prev_valid_reg, prev_valid_next;
    logic              force_pend_reg, force_pend_next;
    logic              triggered_reg,  triggered_next;
    logic [ADDR_W-1:0] wr_ptr_reg,     wr_ptr_next;
    logic [ADDR_W-1:0] fill_cnt_reg,   fill_cnt_next;
    logic [ADDR_W-1:0] post_cnt_reg,   post_cnt_next;
    logic [ADDR_W-1:0] start_ptr_reg,  start_ptr_next;

    // ---------------- combinational helpers ----------------
    logic              strobe;
    logic              busy_now;
    logic              level_hit;
    logic              trig_hit;
    logic              wr_en;
    logic [ADDR_W-1:0] phys_rd_addr;

    // One strobe per rising edge of tick_in, however long it stays high.
    assign strobe   = bus.tick_in & ~tick_q_reg;
    assign busy_now = state_is_busy(state_reg);

    always_comb begin
        level_hit = 1'b0;
        if (bus.trig_slope == SLOPE_FALL) begin
            level_hit = (prev_reg > bus.trig_level) && (bus.adc_data <= bus.trig_level);
        end else begin
            level_hit = (prev_reg < bus.trig_level) && (bus.adc_data >= bus.trig_level);
        end
    end

    // A forced trigger requested in the same cycle as an ARMED strobe fires
    // immediately rather than waiting another sample period.
    assign trig_hit = (prev_valid_reg & level_hit) | force_pend_reg | bus.force_trig;

    // ---------------- next-state / datapath ----------------
    always_comb begin
        state_next      = state_reg;
        prev_next       = prev_reg;
        prev_valid_next = prev_valid_reg;
        force_pend_next = force_pend_reg;
        triggered_next  = triggered_reg;
        wr_ptr_next     = wr_ptr_reg;
        fill_cnt_next   = fill_cnt_reg;
        post_cnt_next   = post_cnt_reg;
        start_ptr_next  = start_ptr_reg;
        wr_en           = 1'b0;

        if (busy_now && bus.force_trig) begin
            force_pend_next = 1'b1;
        end

        if (busy_now && strobe) begin
            prev_next       = bus.adc_data;
            prev_valid_next = 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (bus.arm) begin
                    state_next      = FILL;
                    wr_ptr_next     = '0;
                    fill_cnt_next   = '0;
                    force_pend_next = 1'b0;
                    prev_valid_next = 1'b0;
                end
            end

            FILL: begin
                // Triggers are not evaluated until the pre-trigger history
                // is complete; a force request stays pending.
                if (strobe) begin
                    wr_en         = 1'b1;
                    wr_ptr_next   = wr_ptr_reg + ONE_A;
                    fill_cnt_next = fill_cnt_reg + ONE_A;
                    if ((fill_cnt_reg + ONE_A) == PRE_A) begin
                        state_next = ARMED;
                    end
                end
            end

            ARMED: begin
                if (strobe) begin
                    wr_en       = 1'b1;
                    wr_ptr_next = wr_ptr_reg + ONE_A;
                    if (trig_hit) begin
                        // Record starts PRE_DEPTH samples before the write
                        // holding the trigger sample; wraps at ADDR_W bits.
                        start_ptr_next  = wr_ptr_reg - PRE_A;
                        post_cnt_next   = POST_INIT;
                        triggered_next  = 1'b1;
                        force_pend_next = 1'b0;
                        state_next      = POST_EMPTY ? DONE : POST;
                    end
                end
            end

            POST: begin
                if (strobe) begin
                    wr_en         = 1'b1;
                    wr_ptr_next   = wr_ptr_reg + ONE_A;
                    post_cnt_next = post_cnt_reg - ONE_A;
                    if (post_cnt_reg == ONE_A) begin
                        state_next = DONE;
                    end
                end
            end

            DONE: begin
                if (bus.arm) begin
                    state_next      = FILL;
                    wr_ptr_next     = '0;
                    fill_cnt_next   = '0;
                    triggered_next  = 1'b0;
                    force_pend_next = 1'b0;
                    prev_valid_next = 1'b0;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            tick_q_reg     <= 1'b0;
            prev_reg       <= '0;
            prev_valid_reg <= 1'b0;
            force_pend_reg <= 1'b0;
            triggered_reg  <= 1'b0;
            wr_ptr_reg     <= '0;
            fill_cnt_reg   <= '0;
            post_cnt_reg   <= '0;
            start_ptr_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            tick_q_reg     <= bus.tick_in;
            prev_reg       <= prev_next;
            prev_valid_reg <= prev_valid_next;
            force_pend_reg <= force_pend_next;
            triggered_reg  <= triggered_next;
            wr_ptr_reg     <= wr_ptr_next;
            fill_cnt_reg   <= fill_cnt_next;
            post_cnt_reg   <= post_cnt_next;
            start_ptr_reg  <= start_ptr_next;
        end
    end

    // ---------------- sample store ----------------
    // Logical index to physical address, natural wrap at ADDR_W bits.
    assign phys_rd_addr = start_ptr_reg + bus.rd_addr;

    capture_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_reg),
        .wr_data (bus.adc_data),
        .rd_addr (phys_rd_addr),
        .rd_data (bus.rd_data)
    );

    // ---------------- status outputs ----------------
    assign bus.busy      = busy_now;
    assign bus.triggered = triggered_reg;
    assign bus.done      = (state_reg == DONE);

endmodule
